// File: rtl/axis_rr_packet_mux_pkg.sv
// Shared AXIS helpers: mux FSM state type and a wrapping round-robin search.
package axi_ifs;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } axis_mux_state_t;

  localparam int unsigned RR_MAX_CH = 16;

  // Returns the first set bit of req at or after ptr, wrapping at num_ch.
  // Searching from the farthest offset back toward ptr lets the nearest hit win.
  function automatic logic [3:0] rr_next(input logic [RR_MAX_CH-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int unsigned          num_ch);
    logic [3:0]  grant;
    int unsigned idx;
    grant = ptr;
    for (int unsigned k = RR_MAX_CH; k > 0; k--) begin
      if (k <= num_ch) begin
        idx = 32'(ptr) + k - 1;
        if (idx >= num_ch) idx = idx - num_ch;
        if (req[idx[3:0]]) grant = idx[3:0];
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/axis_rr_packet_mux_skid_buffer.sv
// Two-entry AXIS skid buffer with registered outputs and a ready that depends
// only on flop state, so the downstream ready never reaches the upstream ready.
module axis_skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;

  assign in_ready = ~skid_valid;

  // Main register loads when free; a beat arriving during a stall parks in the skid slot.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!skid_valid) begin
      if (out_ready || !out_valid) begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end else if (in_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (out_ready) begin
      out_data   <= skid_data;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_rr_packet_mux.sv
// N-channel AXIS packet mux: round-robin grant held until tlast, output through
// a skid buffer, optional tid tagging with the source channel index.
module axis_rr_packet_mux
  import axi_ifs::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned ID_MODE    = 1
) (
  input  logic                           clk,
  input  logic                           resn,
  input  logic [NUM_CH-1:0]              s_tvalid,
  output logic [NUM_CH-1:0]              s_tready,
  input  logic [NUM_CH-1:0]              s_tlast,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_CH*DEST_WIDTH-1:0]   s_tdest,
  input  logic [NUM_CH*ID_WIDTH-1:0]     s_tid,
  input  logic [NUM_CH*USER_WIDTH-1:0]   s_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [DEST_WIDTH-1:0]          m_tdest,
  output logic [ID_WIDTH-1:0]            m_tid,
  output logic [USER_WIDTH-1:0]          m_tuser,
  output logic [15:0]                    pkt_count,
  output logic [$clog2(NUM_CH)-1:0]      active_ch,
  output logic                           busy
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned BEAT_W = 1 + USER_WIDTH + ID_WIDTH + DEST_WIDTH + DATA_WIDTH;

  if (ID_MODE == 1 && ID_WIDTH < CH_W) begin : g_id_width_check
    $error("axis_rr_packet_mux: ID_WIDTH too narrow to hold a channel index");
  end

  axis_mux_state_t   state, state_next;
  logic [CH_W-1:0]   active_next;
  logic [CH_W-1:0]   ptr;
  logic              beat_valid;
  logic              skid_ready;
  logic              out_valid;
  logic [BEAT_W-1:0] beat_in;
  logic [BEAT_W-1:0] beat_out;
  logic [ID_WIDTH-1:0] beat_id;
  int unsigned       sel;

  // Arbitrate in IDLE, then steer the granted channel's handshake into the skid buffer.
  always_comb begin
    state_next  = state;
    active_next = active_ch;
    beat_valid  = 1'b0;
    s_tready    = '0;
    unique case (state)
      IDLE: begin
        if (|s_tvalid) begin
          active_next = CH_W'(rr_next(16'(s_tvalid), 4'(ptr), NUM_CH));
          state_next  = LOCKED;
        end
      end
      LOCKED: begin
        s_tready[active_ch] = skid_ready;
        beat_valid          = s_tvalid[active_ch];
        if (beat_valid && skid_ready && s_tlast[active_ch]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers; pointer moves past a finished packet.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state     <= IDLE;
      active_ch <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      active_ch <= active_next;
      if (state == LOCKED && state_next == IDLE)
        ptr <= (active_ch == CH_W'(NUM_CH - 1)) ? '0 : active_ch + 1'b1;
    end
  end

  // Select the granted channel's fields; tid is optionally replaced by the channel index.
  always_comb begin
    sel     = 32'(active_ch);
    beat_id = (ID_MODE == 1) ? ID_WIDTH'(active_ch) : s_tid[sel*ID_WIDTH +: ID_WIDTH];
    beat_in = {s_tlast[active_ch],
               s_tuser[sel*USER_WIDTH +: USER_WIDTH],
               beat_id,
               s_tdest[sel*DEST_WIDTH +: DEST_WIDTH],
               s_tdata[sel*DATA_WIDTH +: DATA_WIDTH]};
  end

  axis_skid_buffer #(.W(BEAT_W)) u_skid (
    .clk       (clk),
    .resn      (resn),
    .in_valid  (beat_valid),
    .in_ready  (skid_ready),
    .in_data   (beat_in),
    .out_valid (out_valid),
    .out_ready (m_tready),
    .out_data  (beat_out)
  );

  assign m_tvalid = out_valid;
  assign {m_tlast, m_tuser, m_tid, m_tdest, m_tdata} = beat_out;
  assign busy = (state == LOCKED);

  // Count packets as their last beat leaves the output port.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) pkt_count <= '0;
    else if (out_valid && m_tready && m_tlast) pkt_count <= pkt_count + 16'd1;
  end

endmodule

// File: tb/tb_axis_rr_packet_mux.sv
// Bench for axis_rr_packet_mux: per-channel packet sources, a packet-level
// round-robin reference model, and checks of ordering, timing, stalls and reset.
module tb_axis_rr_packet_mux;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEW = 4;
  localparam int IW  = 2;
  localparam int UW  = 4;

  logic              clk = 1'b0;
  logic              resn;
  logic [NCH-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH*DEW-1:0] s_tdest;
  logic [NCH*IW-1:0] s_tid;
  logic [NCH*UW-1:0] s_tuser;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [DEW-1:0]    m_tdest;
  logic [IW-1:0]     m_tid;
  logic [UW-1:0]     m_tuser;
  logic [15:0]       pkt_count;
  logic [1:0]        active_ch;
  logic              busy;

  always #5 clk = ~clk;

  axis_rr_packet_mux #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .DEST_WIDTH(DEW),
    .ID_WIDTH(IW), .USER_WIDTH(UW), .ID_MODE(1)
  ) dut (
    .clk(clk), .resn(resn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tdest(s_tdest), .s_tid(s_tid), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tid(m_tid), .m_tuser(m_tuser),
    .pkt_count(pkt_count), .active_ch(active_ch), .busy(busy)
  );

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
    logic [DEW-1:0] dest;
    logic [DW-1:0] data;
  } beat_t;

  int    tests_run = 0;
  int    tests_failed = 0;
  beat_t src_q[NCH][$];
  beat_t exp_q[$];
  int    stall_cnt[NCH];
  int    stall_plan[NCH];
  bit    stall_rand, rnd_ready;
  int    cyc, first_valid_cyc, exp_ptr, exp_pkts;
  int    out_cyc[$];
  int    out_tid[$];
  int    pkt_tid[$];
  bit    prev_stall;
  logic [18:0] prev_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = 8'($urandom);
    b.dest = 4'($urandom);
    b.user = 4'($urandom);
    b.id   = 2'($urandom);
    b.last = last;
    return b;
  endfunction

  function automatic int src_left();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += src_q[c].size();
    return n;
  endfunction

  task automatic load_pkt(input int ch, input int len);
    for (int i = 0; i < len; i++) src_q[ch].push_back(rand_beat(i == len - 1));
  endtask

  // Reference: whole packets leave in round-robin order over channels holding packets.
  task automatic build_expected();
    beat_t pend[NCH][$];
    beat_t b;
    int    found;
    for (int c = 0; c < NCH; c++) pend[c] = src_q[c];
    forever begin
      found = -1;
      for (int k = 0; k < NCH; k++)
        if (found < 0 && pend[(exp_ptr + k) % NCH].size() > 0) found = (exp_ptr + k) % NCH;
      if (found < 0) break;
      do begin
        b = pend[found].pop_front();
        b.id = IW'(found);
        exp_q.push_back(b);
      end while (!b.last);
      exp_pkts++;
      exp_ptr = (found + 1) % NCH;
    end
  endtask

  task automatic drive();
    logic [NCH-1:0]     tv, tl;
    logic [NCH*DW-1:0]  td;
    logic [NCH*DEW-1:0] tde;
    logic [NCH*IW-1:0]  ti;
    logic [NCH*UW-1:0]  tu;
    beat_t b;
    tv = '0; tl = '0; td = '0; tde = '0; ti = '0; tu = '0;
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (src_q[ch].size() > 0) begin
        if (stall_cnt[ch] > 0) begin
          stall_cnt[ch]--;
        end else begin
          b = src_q[ch][0];
          tv[ch] = 1'b1;
          tl[ch] = b.last;
          td[ch*DW +: DW]   = b.data;
          tde[ch*DEW +: DEW] = b.dest;
          ti[ch*IW +: IW]   = b.id;
          tu[ch*UW +: UW]   = b.user;
        end
      end
    end
    if (|tv && first_valid_cyc < 0) first_valid_cyc = cyc + 1;
    s_tvalid = tv; s_tlast = tl; s_tdata = td; s_tdest = tde; s_tid = ti; s_tuser = tu;
  endtask

  // One clock: sample handshakes at the falling edge, drive new inputs after the rising edge.
  task automatic step();
    beat_t b, e;
    logic [18:0] cur;
    @(negedge clk);
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (resn && s_tvalid[ch] && s_tready[ch]) begin
        b = src_q[ch].pop_front();
        if (!b.last) begin
          stall_cnt[ch] = stall_rand ? int'($urandom_range(0, 3)) : stall_plan[ch];
          stall_plan[ch] = 0;
        end
      end
    end
    cur = {m_tlast, m_tuser, m_tid, m_tdest, m_tdata};
    if (prev_stall) begin
      chk("stall_valid", 32'(m_tvalid), 32'(1));
      chk("stall_fields", 32'(cur), 32'(prev_beat));
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(m_tvalid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 32'(cur), 32'(e));
      end
      out_cyc.push_back(cyc);
      out_tid.push_back(int'(m_tid));
      if (m_tlast) pkt_tid.push_back(int'(m_tid));
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = cur;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_left() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size() + src_left()), 32'(0));
    repeat (4) step();
    chk("pkt_count", 32'(pkt_count), 32'(exp_pkts & 16'hFFFF));
  endtask

  task automatic begin_test();
    out_cyc.delete();
    out_tid.delete();
    pkt_tid.delete();
    first_valid_cyc = -1;
  endtask

  task automatic clear_tb();
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      stall_cnt[c]  = 0;
      stall_plan[c] = 0;
    end
    exp_q.delete();
    prev_stall = 1'b0;
    exp_ptr  = 0;
    exp_pkts = 0;
    begin_test();
  endtask

  task automatic check_reset_outputs();
    chk("rst_m_tvalid", 32'(m_tvalid), 32'(0));
    chk("rst_m_fields", 32'({m_tlast, m_tuser, m_tid, m_tdest, m_tdata}), 32'(0));
    chk("rst_s_tready", 32'(s_tready), 32'(0));
    chk("rst_pkt_count", 32'(pkt_count), 32'(0));
    chk("rst_status", 32'({busy, active_ch}), 32'(0));
  endtask

  task automatic do_reset();
    resn = 1'b0;
    clear_tb();
    drive();
    repeat (3) step();
    check_reset_outputs();
    resn = 1'b1;
    step();
  endtask

  initial begin
    int total, ch, len;
    resn = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tdest = '0; s_tid = '0; s_tuser = '0;
    m_tready = 1'b1;
    stall_rand = 1'b0;
    rnd_ready  = 1'b0;
    cyc = 0;
    do_reset();

    // Single 3-beat packet on ch2.
    begin_test();
    load_pkt(2, 3);
    for (int i = 0; i < 3; i++) src_q[2][i].data = 8'hA1 + 8'(i);
    build_expected();
    drive();
    run(50);
    chk("t1_beats", 32'(out_cyc.size()), 32'(3));
    if (out_cyc.size() == 3) begin
      chk("t1_latency", 32'(out_cyc[0] - first_valid_cyc), 32'(2));
      chk("t1_back_to_back", 32'(out_cyc[2] - out_cyc[0]), 32'(2));
    end
    if (pkt_tid.size() > 0) chk("t1_tid", 32'(pkt_tid[0]), 32'(2));

    // All channels at once after reset: order 0..3, one bubble between packets.
    do_reset();
    begin_test();
    for (int c = 0; c < NCH; c++) load_pkt(c, 2);
    build_expected();
    drive();
    run(100);
    chk("t2_beats", 32'(out_cyc.size()), 32'(8));
    if (out_cyc.size() == 8)
      for (int k = 1; k < 8; k++)
        chk("t2_gap", 32'(out_cyc[k] - out_cyc[k-1]), (k % 2 == 1) ? 32'(1) : 32'(2));
    if (pkt_tid.size() == 4)
      for (int p = 0; p < 4; p++) chk("t2_order", 32'(pkt_tid[p]), 32'(p));

    // Wrap from ch3 to ch1, then skip idle ch2 to reach ch3.
    begin_test();
    load_pkt(3, 2);
    build_expected();
    drive();
    run(50);
    begin_test();
    load_pkt(1, 2);
    load_pkt(3, 3);
    build_expected();
    drive();
    run(80);
    chk("t3_npkt", 32'(pkt_tid.size()), 32'(2));
    if (pkt_tid.size() == 2) begin
      chk("t3_wrap", 32'(pkt_tid[0]), 32'(1));
      chk("t3_skip", 32'(pkt_tid[1]), 32'(3));
    end

    // Granted ch0 drops valid for 5 cycles mid-packet while ch1 waits.
    begin_test();
    load_pkt(0, 4);
    load_pkt(1, 2);
    stall_plan[0] = 5;
    build_expected();
    drive();
    run(100);
    chk("t4_beats", 32'(out_tid.size()), 32'(6));
    if (out_tid.size() == 6) begin
      for (int k = 0; k < 4; k++) chk("t4_ch0_first", 32'(out_tid[k]), 32'(0));
      chk("t4_stall_gap", 32'(out_cyc[1] - out_cyc[0]), 32'(6));
    end

    // Random traffic with random output backpressure and random mid-packet gaps.
    begin_test();
    stall_rand = 1'b1;
    rnd_ready  = 1'b1;
    total = 0;
    while (total < 200) begin
      ch  = int'($urandom_range(0, NCH - 1));
      len = int'($urandom_range(1, 6));
      load_pkt(ch, len);
      total += len;
    end
    build_expected();
    drive();
    run(4000);
    chk("t5_beats", 32'(out_cyc.size()), 32'(total));
    stall_rand = 1'b0;
    rnd_ready  = 1'b0;

    // Reset asserted in the middle of a ch2 packet.
    begin_test();
    load_pkt(2, 6);
    build_expected();
    drive();
    repeat (5) step();
    #3;
    resn = 1'b0;
    #1;
    check_reset_outputs();
    clear_tb();
    drive();
    repeat (2) step();
    resn = 1'b1;
    step();
    begin_test();
    load_pkt(2, 2);
    load_pkt(0, 2);
    build_expected();
    drive();
    run(60);
    chk("t6_npkt", 32'(pkt_tid.size()), 32'(2));
    if (pkt_tid.size() > 0) chk("t6_first_ch", 32'(pkt_tid[0]), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
